condicionador_entrada: RTL

CONDICIONADOR_ENTRADA -- requirements
Module: condicionador_entrada

---
 rtl/condicionador_entrada.sv | 108 ++++++++++
 1 files changed

// File: rtl/condicionador_entrada.sv
// Purpose: synchronize and debounce a push-button, capture a BCD digit from switches on each press.
// Latency: button held from before edge E0 -> insere/erro pulse after edge E(DEBOUNCE_CYCLES+1).
// Backpressure: none; insere/erro are single-cycle strobes the downstream lock must take as they come.
module condicionador_entrada #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       botao,
    input  logic [4:1] chaves,
    output logic       insere,
    output logic [4:1] numero,
    output logic       erro
);

    // Counter only has to reach DEBOUNCE_CYCLES-1, but size it for the full value.
    localparam int                CNT_W   = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]        MAX_BCD = 4'd9;

    // Two-flop synchronizers: _m is the metastability stage, _s the usable sample.
    logic             botao_m_q,  botao_m_d;
    logic             botao_s_q,  botao_s_d;
    logic [4:1]       chaves_m_q, chaves_m_d;
    logic [4:1]       chaves_s_q, chaves_s_d;

    // Debounce state.
    logic             estavel_q,  estavel_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;

    // Registered outputs.
    logic             insere_q,   insere_d;
    logic             erro_q,     erro_d;
    logic [4:1]       numero_q,   numero_d;

    // Asserted on the edge where the debounced level rises 0->1.
    logic             press;

    // Synchronizer next-state: shift the raw inputs through two stages.
    always_comb begin
        botao_m_d  = botao;
        botao_s_d  = botao_m_q;
        chaves_m_d = chaves;
        chaves_s_d = chaves_m_q;
    end

    // Debounce: the stable level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        estavel_d = estavel_q;
        cnt_d     = cnt_q;
        press     = 1'b0;
        if (botao_s_q == estavel_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            estavel_d = botao_s_q;
            cnt_d     = '0;
            // Only the rising transition is a press; release is silent.
            press     = botao_s_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Press classification: valid BCD digit is captured, anything above 9 flags an error.
    always_comb begin
        insere_d = 1'b0;
        erro_d   = 1'b0;
        numero_d = numero_q;
        if (press) begin
            if (chaves_s_q <= MAX_BCD) begin
                insere_d = 1'b1;
                numero_d = chaves_s_q;
            end else begin
                erro_d   = 1'b1;
            end
        end
    end

    // State register with synchronous reset taking priority over every update.
    always_ff @(posedge clk) begin
        if (reset) begin
            botao_m_q  <= 1'b0;
            botao_s_q  <= 1'b0;
            chaves_m_q <= 4'b0000;
            chaves_s_q <= 4'b0000;
            estavel_q  <= 1'b0;
            cnt_q      <= '0;
            insere_q   <= 1'b0;
            erro_q     <= 1'b0;
            numero_q   <= 4'b0000;
        end else begin
            botao_m_q  <= botao_m_d;
            botao_s_q  <= botao_s_d;
            chaves_m_q <= chaves_m_d;
            chaves_s_q <= chaves_s_d;
            estavel_q  <= estavel_d;
            cnt_q      <= cnt_d;
            insere_q   <= insere_d;
            erro_q     <= erro_d;
            numero_q   <= numero_d;
        end
    end

    assign insere = insere_q;
    assign erro   = erro_q;
    assign numero = numero_q;

endmodule
